fpga_receiver: RTL

Receive side of the FPGA-to-FPGA serial link. It accepts the request/finish/data wires driven by the peer board's transmitter FSM and answers each phase with a one-cycle `acknowledge` pulse. It deserializes DATA_WIDTH bits, LSB first, into a parallel word and presents the word to local logic with a one-cycle `received` strobe. It sits at the board edge, between the inter-board header pins and the local consumer.

---
 rtl/fpga_receiver_pkg.sv | 16 +
 rtl/fpga_rx_sync.sv | 25 ++
 rtl/fpga_receiver.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/fpga_receiver_pkg.sv
// Shared definitions for the FPGA-to-FPGA link receiver:
// FSM state encoding and default frame/timeout sizing.
package fpga_receiver_pkg;

  localparam int DEF_DATA_WIDTH     = 8;
  localparam int DEF_TIMEOUT_CYCLES = 1024;

  localparam logic [2:0] S_IDLE        = 3'd0;
  localparam logic [2:0] S_START_ACK   = 3'd1;
  localparam logic [2:0] S_WAIT_BIT    = 3'd2;
  localparam logic [2:0] S_BIT_ACK     = 3'd3;
  localparam logic [2:0] S_WAIT_FINISH = 3'd4;
  localparam logic [2:0] S_FINISH_ACK  = 3'd5;
  localparam logic [2:0] S_DONE        = 3'd6;

endpackage

// File: rtl/fpga_rx_sync.sv
// Two-flop synchronizer for one peer-board input line,
// cleared by the asynchronous active-high reset.
module fpga_rx_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/fpga_receiver.sv
// Receive side of the inter-board serial link (LSB-first, per-phase ack).
// Define FPGA_RX_SYNC_EN to pass the peer lines through 2-flop synchronizers.
module fpga_receiver
  import fpga_receiver_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sendFromOther,
  input  logic                  finishFromOther,
  input  logic                  dataFromOther,
  output logic                  acknowledge,
  output logic [DATA_WIDTH-1:0] dataOut,
  output logic                  received,
  output logic                  busy,
  output logic                  error
);

  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam int WW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LP_FULL    = CW'(DATA_WIDTH);
  localparam logic [WW-1:0] LP_WD_INIT = WW'(TIMEOUT_CYCLES - 1);

  logic w_send;
  logic w_finish;
  logic w_data;

`ifdef FPGA_RX_SYNC_EN
  fpga_rx_sync u_sync_send (
    .i_clk (clk),
    .i_rst (reset),
    .i_d   (sendFromOther),
    .o_q   (w_send)
  );
  fpga_rx_sync u_sync_finish (
    .i_clk (clk),
    .i_rst (reset),
    .i_d   (finishFromOther),
    .o_q   (w_finish)
  );
  fpga_rx_sync u_sync_data (
    .i_clk (clk),
    .i_rst (reset),
    .i_d   (dataFromOther),
    .o_q   (w_data)
  );
`else
  assign w_send   = sendFromOther;
  assign w_finish = finishFromOther;
  assign w_data   = dataFromOther;
`endif

  logic [2:0]            r_state;
  logic [2:0]            w_next;
  logic                  w_err;
  logic                  r_send_q;
  logic                  w_rise;
  logic                  r_error;
  logic [CW-1:0]         r_count;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] r_dout;
  logic [WW-1:0]         r_wdog;
  logic                  w_wd_zero;

  assign w_rise    = w_send & ~r_send_q;
  assign w_wd_zero = (r_wdog == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // finish beats a simultaneous rise; the watchdog only fires when nothing else happens
  always_comb begin
    w_next = r_state;
    w_err  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_rise) w_next = S_START_ACK;
      end
      S_START_ACK: w_next = S_WAIT_BIT;
      S_WAIT_BIT: begin
        if (w_finish) begin
          w_err  = 1'b1;
          w_next = S_IDLE;
        end else if (w_rise) begin
          w_next = S_BIT_ACK;
        end else if (w_wd_zero) begin
          w_err  = 1'b1;
          w_next = S_IDLE;
        end
      end
      S_BIT_ACK: begin
        if (r_count == LP_FULL) w_next = S_WAIT_FINISH;
        else                    w_next = S_WAIT_BIT;
      end
      S_WAIT_FINISH: begin
        if (w_finish) begin
          w_next = S_FINISH_ACK;
        end else if (w_rise || w_wd_zero) begin
          w_err  = 1'b1;
          w_next = S_IDLE;
        end
      end
      S_FINISH_ACK: w_next = S_DONE;
      S_DONE:       w_next = S_IDLE;
      default:      w_next = S_IDLE;
    endcase
  end

  always_comb begin
    acknowledge = (r_state == S_START_ACK) ||
                  (r_state == S_BIT_ACK) ||
                  (r_state == S_FINISH_ACK);
    received    = (r_state == S_DONE);
    busy        = (r_state != S_IDLE);
    error       = r_error;
    dataOut     = r_dout;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_send_q <= 1'b0;
      r_error  <= 1'b0;
      r_count  <= '0;
      r_shift  <= '0;
      r_dout   <= '0;
      r_wdog   <= LP_WD_INIT;
    end else begin
      r_send_q <= w_send;
      r_error  <= w_err;
      if (r_state == S_START_ACK) begin
        r_count <= '0;
        r_shift <= '0;
      end else if (r_state == S_WAIT_BIT && w_next == S_BIT_ACK) begin
        r_shift <= {w_data, r_shift[DATA_WIDTH-1:1]};
        r_count <= r_count + CW'(1);
      end
      if (r_state == S_FINISH_ACK) r_dout <= r_shift;
      if (w_next != r_state) begin
        r_wdog <= LP_WD_INIT;
      end else if ((r_state == S_WAIT_BIT || r_state == S_WAIT_FINISH) &&
                   !w_wd_zero) begin
        r_wdog <= r_wdog - WW'(1);
      end
    end
  end

endmodule
